// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the dual-page framebuffer.
package fb_pkg;

  localparam int FB_W_DEF     = 32;
  localparam int FB_H_DEF     = 60;
  localparam int PIX_BITS_DEF = 4;

  // IDLE accepts pixel writes; CLEAR owns the back-page write port.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_page_ram.sv
// One framebuffer page: simple dual-port RAM, one write port, one
// synchronous read port, read-before-write on an address collision.
module fb_page_ram #(
  parameter int DEPTH = 1920,
  parameter int AW    = 11,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port, no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_page_framebuffer.sv
// Double-buffered framebuffer: pixel writes and hardware clears go to the
// back page, the display reads the front page, and a requested swap is
// applied on the next end-of-frame pulse while no clear is running.
//
// Handshake: a pixel write commits on any rising edge where wr_valid and
// wr_ready are both high; wr_ready is high exactly while the clear engine is
// idle and does not depend on wr_valid. Out-of-range coordinates are still
// accepted but leave memory unchanged.
module dual_page_framebuffer
  import fb_pkg::*;
#(
  parameter  int FB_W     = FB_W_DEF,
  parameter  int FB_H     = FB_H_DEF,
  parameter  int PIX_BITS = PIX_BITS_DEF,
  localparam int XW       = $clog2(FB_W),
  localparam int YW       = $clog2(FB_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [XW-1:0]       wr_x,
  input  logic [YW-1:0]       wr_y,
  input  logic [PIX_BITS-1:0] wr_data,
  input  logic [XW-1:0]       rd_x,
  input  logic [YW-1:0]       rd_y,
  output logic [PIX_BITS-1:0] rd_data,
  input  logic                clear_req,
  input  logic [PIX_BITS-1:0] clear_color,
  input  logic                swap_req,
  input  logic                frame_done,
  output logic                busy,
  output logic                swap_pending,
  output logic                front_page
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  fb_state_t           state_q, state_d;
  logic [AW-1:0]       cnt_q;
  logic [PIX_BITS-1:0] color_q;
  logic                front_q;
  logic                pend_q;
  logic                rd_ok_q;
  logic                rd_sel_q;

  logic                wr_in, rd_in;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                page_we;
  logic [AW-1:0]       page_waddr;
  logic [PIX_BITS-1:0] page_wdata;
  logic [PIX_BITS-1:0] rdata0, rdata1;
  logic                last_clear;

  assign wr_in   = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
  assign rd_in   = (int'(rd_x) < FB_W) && (int'(rd_y) < FB_H);
  assign wr_addr = wr_in ? AW'(int'(wr_y) * FB_W + int'(wr_x)) : '0;
  assign rd_addr = rd_in ? AW'(int'(rd_y) * FB_W + int'(rd_x)) : '0;
  assign last_clear = (cnt_q == AW'(DEPTH - 1));

  // State register for the clear engine.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, handshake outputs and back-page write port selection.
  always_comb begin
    state_d    = state_q;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    page_we    = 1'b0;
    page_waddr = '0;
    page_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_in && !rst) begin
          page_we    = 1'b1;
          page_waddr = wr_addr;
          page_wdata = wr_data;
        end
        if (clear_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        page_we    = !rst;
        page_waddr = cnt_q;
        page_wdata = color_q;
        if (last_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear counter/colour, page swap bookkeeping and read-side pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      color_q  <= '0;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      rd_ok_q  <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && clear_req) begin
        cnt_q   <= '0;
        color_q <= clear_color;
      end else if (state_q == ST_CLEAR) begin
        cnt_q <= last_clear ? '0 : cnt_q + AW'(1);
      end
      // A swap already pending consumes frame_done; any swap_req that edge is absorbed.
      if (pend_q && frame_done && state_q == ST_IDLE) begin
        front_q <= !front_q;
        pend_q  <= 1'b0;
      end else if (swap_req) begin
        pend_q <= 1'b1;
      end
      // Page select is captured with the read so a toggle applies to later reads only.
      rd_ok_q  <= rd_in;
      rd_sel_q <= front_q;
    end
  end

  // Page 0 is the back page while page 1 is displayed, and vice versa.
  fb_page_ram #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_BITS)) u_page0 (
    .clk   (clk),
    .we    (page_we && front_q),
    .waddr (page_waddr),
    .wdata (page_wdata),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  fb_page_ram #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_BITS)) u_page1 (
    .clk   (clk),
    .we    (page_we && !front_q),
    .waddr (page_waddr),
    .wdata (page_wdata),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  assign rd_data      = rd_ok_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
  assign front_page   = front_q;
  assign swap_pending = pend_q;

endmodule

// File: tb/tb_dual_page_framebuffer.sv
// Self-checking bench for dual_page_framebuffer: directed scenarios plus a
// randomized phase, all compared against a page-array reference model.
module tb_dual_page_framebuffer;

  localparam int FB_W = 32;
  localparam int FB_H = 60;
  localparam int N    = FB_W * FB_H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_valid, wr_ready;
  logic [4:0] wr_x, rd_x;
  logic [5:0] wr_y, rd_y;
  logic [3:0] wr_data, rd_data, clear_color;
  logic       clear_req, swap_req, frame_done;
  logic       busy, swap_pending, front_page;

  dual_page_framebuffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .clear_req(clear_req), .clear_color(clear_color),
    .swap_req(swap_req), .frame_done(frame_done), .busy(busy),
    .swap_pending(swap_pending), .front_page(front_page)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two page arrays plus a "known" map so pixels never written are not compared.
  logic [3:0] pg [2][N];
  bit         kn [2][N];
  bit         m_front = 0, m_pend = 0, m_busy = 0, started = 0;
  int         m_cnt = 0;
  logic [3:0] m_color = 0;
  logic [3:0] exp_rd = 0;
  bit         exp_rd_known = 1;

  always @(posedge clk) begin
    int  ra, wa;
    bit  rin, win, old_busy, back;
    started = 1;
    if (rst) begin
      m_front = 0; m_pend = 0; m_busy = 0; m_cnt = 0;
      exp_rd = 0; exp_rd_known = 1;
    end else begin
      rin = (rd_x < FB_W) && (rd_y < FB_H);
      ra  = int'(rd_y) * FB_W + int'(rd_x);
      if (!rin) begin
        exp_rd = 0; exp_rd_known = 1;
      end else begin
        exp_rd = pg[m_front][ra]; exp_rd_known = kn[m_front][ra];
      end
      old_busy = m_busy;
      back     = !m_front;
      if (m_busy) begin
        pg[back][m_cnt] = m_color; kn[back][m_cnt] = 1;
        m_cnt++;
        if (m_cnt == N) m_busy = 0;
      end else begin
        win = (wr_x < FB_W) && (wr_y < FB_H);
        wa  = int'(wr_y) * FB_W + int'(wr_x);
        if (wr_valid && win) begin
          pg[back][wa] = wr_data; kn[back][wa] = 1;
        end
        if (clear_req) begin
          m_busy = 1; m_cnt = 0; m_color = clear_color;
        end
      end
      if (m_pend && frame_done && !old_busy) begin
        m_front = !m_front; m_pend = 0;
      end else if (swap_req) begin
        m_pend = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      check("busy", busy, m_busy);
      check("wr_ready", wr_ready, !m_busy);
      check("front_page", front_page, m_front);
      check("swap_pending", swap_pending, m_pend);
      if (exp_rd_known) check("rd_data", rd_data, exp_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input int d);
    wr_valid = 1; wr_x = 5'(x); wr_y = 6'(y); wr_data = 4'(d);
    tick();
    wr_valid = 0;
  endtask

  task automatic read_px(input int x, input int y, output logic [3:0] v);
    rd_x = 5'(x); rd_y = 6'(y);
    tick();
    v = rd_data;
  endtask

  task automatic pulse_swap(); swap_req = 1; tick(); swap_req = 0; endtask
  task automatic pulse_frame(); frame_done = 1; tick(); frame_done = 0; endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 4000) begin tick(); g++; end
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic do_clear(input int color);
    clear_color = 4'(color); clear_req = 1; tick(); clear_req = 0;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] v;
    int cnt, bad, ready_seen;
    rst = 1; wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0; rd_x = 0; rd_y = 0;
    clear_req = 0; clear_color = 0; swap_req = 0; frame_done = 0;
    repeat (3) tick();
    rst = 0;
    check("reset_busy", busy, 0);
    check("reset_wr_ready", wr_ready, 1);
    check("reset_front", front_page, 0);
    check("reset_pending", swap_pending, 0);
    check("reset_rd_data", rd_data, 0);

    // Write, swap on frame_done, read back from new front page.
    write_px(3, 5, 7);
    pulse_swap();
    check("swap_pending_set", swap_pending, 1);
    pulse_frame();
    check("front_after_swap", front_page, 1);
    check("pending_after_swap", swap_pending, 0);
    read_px(3, 5, v);
    check("read_3_5", v, 7);

    // Clear page 0 with colour 2; frame_done during clear must not swap.
    clear_color = 2; clear_req = 1; tick(); clear_req = 0;
    cnt = 0; ready_seen = 0;
    while (busy && cnt < 3000) begin
      if (wr_ready) ready_seen++;
      if (cnt == 10)  swap_req = 1;
      if (cnt == 500) frame_done = 1;
      if (cnt == 700) clear_req = 1;
      tick();
      swap_req = 0; frame_done = 0; clear_req = 0;
      cnt++;
    end
    check("clear_busy_cycles", cnt, 1920);
    check("clear_wr_ready_low", ready_seen, 0);
    check("no_swap_during_clear", front_page, 1);
    check("pending_kept", swap_pending, 1);
    pulse_frame();
    check("deferred_swap_front", front_page, 0);
    check("deferred_swap_pending", swap_pending, 0);
    bad = 0;
    for (int a = 0; a < N; a++) begin
      read_px(a % FB_W, a / FB_W, v);
      if (v != 4'd2) bad++;
    end
    check("cleared_pixels_not_2", bad, 0);

    // Clear page 1 so every pixel is known, then show it.
    do_clear(5);
    pulse_swap();
    pulse_frame();
    check("front_after_second_clear", front_page, 1);

    // Out-of-range write accepted but dropped; out-of-range read is zero.
    wr_valid = 1; wr_x = 3; wr_y = 62; wr_data = 15;
    check("oor_wr_ready", wr_ready, 1);
    tick(); wr_valid = 0;
    read_px(3, 62, v);
    check("oor_read_zero", v, 0);
    read_px(31, 59, v);
    check("last_pixel_page1", v, 5);

    // Double swap_req gives a single toggle.
    pulse_swap();
    pulse_swap();
    pulse_frame();
    check("double_swap_front", front_page, 0);
    check("double_swap_pending", swap_pending, 0);
    pulse_frame();
    check("second_frame_no_toggle", front_page, 0);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 6000; i++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      wr_valid   = $urandom_range(0, 1);
      wr_x       = 5'($urandom_range(0, 31));
      wr_y       = 6'($urandom_range(0, 63));
      wr_data    = 4'($urandom_range(0, 15));
      rd_x       = 5'($urandom_range(0, 31));
      rd_y       = 6'($urandom_range(0, 63));
      clear_req  = ($urandom_range(0, 299) == 0);
      clear_color = 4'($urandom_range(0, 15));
      swap_req   = ($urandom_range(0, 19) == 0);
      frame_done = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 0; wr_valid = 0; clear_req = 0; swap_req = 0; frame_done = 0;
    tick();
    wait_idle();

    // Reset during a clear: partial fill survives, control state resets.
    if (!front_page) begin pulse_swap(); pulse_frame(); end
    check("front_before_abort", front_page, 1);
    clear_color = 9; clear_req = 1; tick(); clear_req = 0;
    swap_req = 1; tick(); swap_req = 0;
    repeat (98) tick();
    check("pending_before_abort", swap_pending, 1);
    rst = 1; tick(); rst = 0;
    check("abort_busy", busy, 0);
    check("abort_front", front_page, 0);
    check("abort_pending", swap_pending, 0);
    check("abort_wr_ready", wr_ready, 1);
    read_px(0, 0, v);
    check("abort_pixel0", v, 9);
    read_px(2, 3, v);
    check("abort_pixel98", v, 9);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
